// File: rtl/prefetch_queue_pkg.sv
// Shared constants for the instruction prefetch queue and its window rotator.
package prefetch_queue_pkg;

  localparam int          PQ_WINDOW_BYTES   = 16;
  localparam int          PQ_MAX_INSN_LEN   = 15;
  localparam logic [31:0] RESET_LINEAR_ADDR = 32'hFFFF_FFF0;

endpackage

// File: rtl/prefetch_window.sv
// Combinational rotator: maps the byte ring, read pointer and fill level onto
// the decoder's zero-padded 16-byte window and its saturated byte count.
import prefetch_queue_pkg::*;

module prefetch_window #(
  parameter int DEPTH = 32
) (
  input  logic [7:0]                   ring   [0:DEPTH-1],
  input  logic [$clog2(DEPTH)-1:0]     rd_ptr,
  input  logic [$clog2(DEPTH+1)-1:0]   used,
  output logic [7:0]                   window [0:PQ_WINDOW_BYTES-1],
  output logic [4:0]                   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int UW = $clog2(DEPTH+1);

  // Slots past the fill level read as zero so stale ring bytes never leak out.
  always_comb begin
    for (int k = 0; k < PQ_WINDOW_BYTES; k++) begin
      window[k] = 8'h00;
      if (UW'(k) < used)
        window[k] = ring[rd_ptr + PW'(k)];
    end
    count = (used > UW'(PQ_WINDOW_BYTES)) ? 5'(PQ_WINDOW_BYTES) : 5'(used);
  end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: byte ring fed by dword fetches, drained by the
// decoder in 1-15 byte steps, with flush-and-redirect to a new linear address.
import prefetch_queue_pkg::*;

module prefetch_queue #(
  parameter int          DEPTH      = 32,
  parameter logic [31:0] RESET_ADDR = RESET_LINEAR_ADDR
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic [31:0] i_flush_addr,
  output logic [31:0] o_fetch_addr,
  input  logic        i_fill_valid,
  output logic        o_fill_ready,
  input  logic [31:0] i_fill_data,
  output logic [7:0]  o_window [0:PQ_WINDOW_BYTES-1],
  output logic [4:0]  o_count,
  output logic [31:0] o_head_addr,
  input  logic        i_consume_valid,
  input  logic [3:0]  i_consume_len,
  output logic        o_error
);

  localparam int PW = $clog2(DEPTH);
  localparam int UW = $clog2(DEPTH+1);

  logic [7:0]    ring [0:DEPTH-1];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [UW-1:0] used;
  logic [1:0]    skip;
  logic [31:0]   fetch_addr, head_addr;
  logic          error_q;

  logic          fill_fire, consume_ok, consume_bad;
  logic [2:0]    fill_len;
  logic [UW-1:0] add_len, sub_len;

  prefetch_window #(.DEPTH(DEPTH)) u_window (
    .ring   (ring),
    .rd_ptr (rd_ptr),
    .used   (used),
    .window (o_window),
    .count  (o_count)
  );

  // Ready depends on registered fill level only, so a same-cycle consume never frees space early.
  assign o_fill_ready = (used <= UW'(DEPTH - 4));
  assign fill_fire    = i_fill_valid && o_fill_ready;
  assign fill_len     = 3'd4 - {1'b0, skip};
  assign consume_ok   = i_consume_valid && (i_consume_len != 4'd0) &&
                        ({1'b0, i_consume_len} <= o_count);
  assign consume_bad  = i_consume_valid && !consume_ok;
  assign add_len      = fill_fire  ? UW'(fill_len)      : '0;
  assign sub_len      = consume_ok ? UW'(i_consume_len) : '0;

  assign o_fetch_addr = fetch_addr;
  assign o_head_addr  = head_addr;
  assign o_error      = error_q;

  // Leading bytes below the redirect offset are dropped from the first dword after a flush.
  always_ff @(posedge i_clk) begin
    if (fill_fire && !i_flush) begin
      for (int j = 0; j < 4; j++) begin
        if (j >= int'(skip))
          ring[wr_ptr + PW'(j - int'(skip))] <= i_fill_data[8*j +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      used       <= '0;
      skip       <= 2'd0;
      fetch_addr <= {RESET_ADDR[31:2], 2'b00};
      head_addr  <= RESET_ADDR;
      error_q    <= 1'b0;
    end else if (i_flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      used       <= '0;
      skip       <= i_flush_addr[1:0];
      fetch_addr <= {i_flush_addr[31:2], 2'b00};
      head_addr  <= i_flush_addr;
      error_q    <= 1'b0;
    end else begin
      used    <= used + add_len - sub_len;
      error_q <= consume_bad;
      if (fill_fire) begin
        wr_ptr     <= wr_ptr + PW'(fill_len);
        skip       <= 2'd0;
        fetch_addr <= fetch_addr + 32'd4;
      end
      if (consume_ok) begin
        rd_ptr    <= rd_ptr + PW'(i_consume_len);
        head_addr <= head_addr + 32'(i_consume_len);
      end
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: directed vector table, random stream
// against a byte-queue reference model, and an asynchronous reset check.
module tb_prefetch_queue;

  localparam int DEPTH = 32;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic [31:0] i_flush_addr;
  logic [31:0] o_fetch_addr;
  logic        i_fill_valid;
  logic        o_fill_ready;
  logic [31:0] i_fill_data;
  logic [7:0]  o_window [0:15];
  logic [4:0]  o_count;
  logic [31:0] o_head_addr;
  logic        i_consume_valid;
  logic [3:0]  i_consume_len;
  logic        o_error;

  prefetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(32'hFFFF_FFF0)) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_flush         (i_flush),
    .i_flush_addr    (i_flush_addr),
    .o_fetch_addr    (o_fetch_addr),
    .i_fill_valid    (i_fill_valid),
    .o_fill_ready    (o_fill_ready),
    .i_fill_data     (i_fill_data),
    .o_window        (o_window),
    .o_count         (o_count),
    .o_head_addr     (o_head_addr),
    .i_consume_valid (i_consume_valid),
    .i_consume_len   (i_consume_len),
    .o_error         (o_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        flush;
    logic [31:0] flush_addr;
    logic        fill_valid;
    logic [31:0] fill_data;
    logic        consume_valid;
    logic [3:0]  consume_len;
    logic [4:0]  exp_count;
    logic [31:0] exp_head;
    logic [31:0] exp_fetch;
    logic        exp_ready;
    logic        exp_error;
    logic [7:0]  exp_w0;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: the queue is simply the ordered list of not-yet-retired bytes.
  byte unsigned mq[$];
  logic [31:0]  m_head, m_fetch;
  int           m_skip;
  logic         m_err;

  function automatic vec_t mk(logic fl, logic [31:0] fa, logic fv, logic [31:0] fd,
                              logic cv, logic [3:0] cl, logic [4:0] ec, logic [31:0] eh,
                              logic [31:0] ef, logic er, logic ee, logic [7:0] ew);
    vec_t v;
    v.flush = fl; v.flush_addr = fa; v.fill_valid = fv; v.fill_data = fd;
    v.consume_valid = cv; v.consume_len = cl; v.exp_count = ec; v.exp_head = eh;
    v.exp_fetch = ef; v.exp_ready = er; v.exp_error = ee; v.exp_w0 = ew;
    return v;
  endfunction

  function automatic logic [7:0] pat(logic [31:0] a);
    logic [31:0] t;
    t = a ^ (a >> 8) ^ (a >> 17) ^ 32'h5A;
    return t[7:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_head  = 32'hFFFF_FFF0;
    m_fetch = 32'hFFFF_FFF0;
    m_skip  = 0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(vec_t s);
    int cnt;
    bit rdy;
    cnt   = (mq.size() > 16) ? 16 : mq.size();
    rdy   = (DEPTH - mq.size()) >= 4;
    m_err = 1'b0;
    if (s.flush) begin
      mq.delete();
      m_head  = s.flush_addr;
      m_fetch = s.flush_addr & 32'hFFFF_FFFC;
      m_skip  = int'(s.flush_addr[1:0]);
    end else begin
      if (s.consume_valid) begin
        if (s.consume_len == 0 || int'(s.consume_len) > cnt) m_err = 1'b1;
        else begin
          for (int i = 0; i < int'(s.consume_len); i++) void'(mq.pop_front());
          m_head = m_head + 32'(s.consume_len);
        end
      end
      if (s.fill_valid && rdy) begin
        for (int j = m_skip; j < 4; j++) mq.push_back(s.fill_data[8*j +: 8]);
        m_skip  = 0;
        m_fetch = m_fetch + 32'd4;
      end
    end
  endtask

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_output(string tag);
    int  exp_cnt;
    bit  win_ok;
    exp_cnt = (mq.size() > 16) ? 16 : mq.size();
    cmp({tag, " count"}, 32'(o_count), 32'(exp_cnt));
    cmp({tag, " head"}, o_head_addr, m_head);
    cmp({tag, " fetch"}, o_fetch_addr, m_fetch);
    cmp({tag, " ready"}, 32'(o_fill_ready), 32'((DEPTH - mq.size()) >= 4));
    cmp({tag, " error"}, 32'(o_error), 32'(m_err));
    win_ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (o_window[k] !== ((k < mq.size()) ? mq[k] : 8'h00)) win_ok = 1'b0;
    end
    tests++;
    if (!win_ok) begin
      fails++;
      $display("[TB] FAIL %s window: got %h..%h, expected first byte %h", tag,
               o_window[0], o_window[15], (mq.size() > 0) ? mq[0] : 8'h00);
    end
  endtask

  task automatic apply_stimulus(vec_t s);
    i_flush         = s.flush;
    i_flush_addr    = s.flush_addr;
    i_fill_valid    = s.fill_valid;
    i_fill_data     = s.fill_data;
    i_consume_valid = s.consume_valid;
    i_consume_len   = s.consume_len;
    model_step(s);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    vec_t s;
    logic [31:0] d;
    int cnt;

    i_rst_n = 1'b0;
    i_flush = 1'b0; i_flush_addr = '0; i_fill_valid = 1'b0; i_fill_data = '0;
    i_consume_valid = 1'b0; i_consume_len = '0;
    model_reset();

    // Directed table (expectations are hand-derived constants).
    vecs.push_back(mk(0, 0, 1, 32'h0302_0100, 0, 0, 5'd4,  32'hFFFF_FFF0, 32'hFFFF_FFF4, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 32'h0706_0504, 0, 0, 5'd8,  32'hFFFF_FFF0, 32'hFFFF_FFF8, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 32'h0B0A_0908, 0, 0, 5'd12, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 32'h0F0E_0D0C, 0, 0, 5'd16, 32'hFFFF_FFF0, 32'h0000_0000, 1, 0, 8'h00));
    vecs.push_back(mk(1, 32'h0000_1003, 0, 0, 0, 0, 5'd0, 32'h0000_1003, 32'h0000_1000, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 32'hDDCC_BBAA, 0, 0, 5'd1, 32'h0000_1003, 32'h0000_1004, 1, 0, 8'hDD));
    vecs.push_back(mk(1, 32'h0000_2000, 0, 0, 0, 0, 5'd0, 32'h0000_2000, 32'h0000_2000, 1, 0, 8'h00));
    for (int k = 0; k < 8; k++) begin
      d = {8'(8'h13 + 4*k), 8'(8'h12 + 4*k), 8'(8'h11 + 4*k), 8'(8'h10 + 4*k)};
      vecs.push_back(mk(0, 0, 1, d, 0, 0, 5'((4*(k+1) > 16) ? 16 : 4*(k+1)), 32'h0000_2000,
                        32'h0000_2000 + 32'(4*(k+1)), (4*(k+1) <= 28), 0, 8'h10));
    end
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'd4, 5'd16, 32'h0000_2004, 32'h0000_2020, 1, 0, 8'h14));
    vecs.push_back(mk(0, 0, 1, 32'h3332_3130, 1, 4'd3, 5'd16, 32'h0000_2007, 32'h0000_2024, 0, 0, 8'h17));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'd15, 5'd14, 32'h0000_2016, 32'h0000_2024, 1, 0, 8'h26));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'd9, 5'd5, 32'h0000_201F, 32'h0000_2024, 1, 0, 8'h2F));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'd6, 5'd5, 32'h0000_201F, 32'h0000_2024, 1, 1, 8'h2F));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'd0, 5'd5, 32'h0000_201F, 32'h0000_2024, 1, 1, 8'h2F));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5'd5, 32'h0000_201F, 32'h0000_2024, 1, 0, 8'h2F));
    vecs.push_back(mk(1, 32'h0000_3006, 1, 32'h1111_1111, 1, 4'd2, 5'd0, 32'h0000_3006, 32'h0000_3004, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 32'hAABB_CCDD, 0, 0, 5'd2, 32'h0000_3006, 32'h0000_3008, 1, 0, 8'hBB));

    #12;
    check_output("reset_held");
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    check_output("reset");

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      cmp($sformatf("vec%0d count", i), 32'(o_count), 32'(vecs[i].exp_count));
      cmp($sformatf("vec%0d head", i), o_head_addr, vecs[i].exp_head);
      cmp($sformatf("vec%0d fetch", i), o_fetch_addr, vecs[i].exp_fetch);
      cmp($sformatf("vec%0d ready", i), 32'(o_fill_ready), 32'(vecs[i].exp_ready));
      cmp($sformatf("vec%0d error", i), 32'(o_error), 32'(vecs[i].exp_error));
      cmp($sformatf("vec%0d w0", i), 32'(o_window[0]), 32'(vecs[i].exp_w0));
      check_output($sformatf("vec%0d model", i));
    end

    // Random stream; fill data is a function of address so the window can be checked against it.
    s = mk(1, 32'hFFFF_FFE5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(s);
    check_output("rnd_start");
    for (int n = 0; n < 600; n++) begin
      cnt = (mq.size() > 16) ? 16 : mq.size();
      s.flush         = ($urandom_range(0, 59) == 0);
      s.flush_addr    = $urandom;
      s.fill_valid    = ($urandom_range(0, 9) < 7);
      for (int j = 0; j < 4; j++) s.fill_data[8*j +: 8] = pat(m_fetch + 32'(j));
      s.consume_valid = ($urandom_range(0, 9) < 6);
      if (cnt == 0 || $urandom_range(0, 14) == 0) s.consume_len = 4'($urandom_range(0, 15));
      else s.consume_len = 4'($urandom_range(1, (cnt > 15) ? 15 : cnt));
      apply_stimulus(s);
      check_output("rnd");
      for (int k = 0; k < 16; k++) begin
        if (k < int'(o_count))
          cmp($sformatf("rnd stream byte%0d", k), 32'(o_window[k]), 32'(pat(o_head_addr + 32'(k))));
      end
    end

    // Asynchronous reset in the middle of fill and consume traffic.
    s = mk(0, 0, 1, 32'h4443_4241, 1, 4'd1, 0, 0, 0, 0, 0, 0);
    i_flush = 1'b0; i_fill_valid = 1'b1; i_fill_data = s.fill_data;
    i_consume_valid = 1'b1; i_consume_len = 4'd1;
    #3;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    check_output("async_reset");
    i_fill_valid = 1'b0; i_consume_valid = 1'b0;
    @(posedge i_clk);
    #1;
    check_output("async_reset_hold");
    i_rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
